// File: rtl/tt_um_jleugeri_ttt_token_router.sv
`default_nettype none
// ==========================================================================
// tt_um_jleugeri_ttt_token_router
// Routes start/stop events to per-target token counters, read-and-cleared
// in each processor's scan slot.
// Revision: 1.0
// ==========================================================================
module tt_um_jleugeri_ttt_token_router #(
  parameter int NEW_TOKEN_BITS = 8,
  parameter int NUM_PROCESSORS = 10,
  localparam int IDW = $clog2(NUM_PROCESSORS)
) (
  input  logic                      clock_fast,
  input  logic                      reset,
  input  logic                      hold,
  input  logic [IDW-1:0]            processor_id,
  input  logic [1:0]                token_startstop,
  input  logic                      prog_en,
  input  logic [IDW-1:0]            prog_id,
  input  logic [IDW-1:0]            prog_target,
  input  logic                      prog_polarity,
  input  logic [1:0]                prog_mode,
  output logic [NEW_TOKEN_BITS-1:0] new_good_tokens,
  output logic [NEW_TOKEN_BITS-1:0] new_bad_tokens,
  output logic                      out_valid,
  output logic [IDW-1:0]            out_id
);

  // Tables span the whole ID space so any ID indexes safely; entries at or
  // above NUM_PROCESSORS are never written and stay zero.
  localparam int                        c_DEPTH = 1 << IDW;
  localparam logic [IDW:0]              c_NUM   = (IDW+1)'(NUM_PROCESSORS);
  localparam logic [NEW_TOKEN_BITS-1:0] c_MAX   = '1;

  logic [IDW-1:0]            r_cfg_target [c_DEPTH];
  logic                      r_cfg_pol    [c_DEPTH];
  logic [1:0]                r_cfg_mode   [c_DEPTH];
  logic [NEW_TOKEN_BITS-1:0] r_pend_good  [c_DEPTH];
  logic [NEW_TOKEN_BITS-1:0] r_pend_bad   [c_DEPTH];

  logic           w_src_ok;
  logic           w_prog_ok;
  logic [1:0]     w_mode;
  logic [IDW-1:0] w_tgt;
  logic           w_pol;
  logic           w_emit;
  logic           w_emit_good;
  logic           w_emit_bad;
  logic           w_self;

  assign w_src_ok  = ({1'b0, processor_id} < c_NUM);
  // A route pointing at a nonexistent processor is rejected along with bad sources.
  assign w_prog_ok = prog_en && ({1'b0, prog_id} < c_NUM) && ({1'b0, prog_target} < c_NUM);

  assign w_mode = r_cfg_mode[processor_id];
  assign w_tgt  = r_cfg_target[processor_id];
  assign w_pol  = r_cfg_pol[processor_id];

  assign w_emit      = w_src_ok && (((token_startstop == 2'b01) && w_mode[0]) ||
                                    ((token_startstop == 2'b10) && w_mode[1]));
  assign w_emit_good = w_emit && !w_pol;
  assign w_emit_bad  = w_emit &&  w_pol;
  assign w_self      = (w_tgt == processor_id);

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_cfg_target[i] <= '0;
        r_cfg_pol[i]    <= 1'b0;
        r_cfg_mode[i]   <= 2'b00;
        r_pend_good[i]  <= '0;
        r_pend_bad[i]   <= '0;
      end
      new_good_tokens <= '0;
      new_bad_tokens  <= '0;
      out_valid       <= 1'b0;
      out_id          <= '0;
    end else begin
      if (w_prog_ok) begin
        r_cfg_target[prog_id] <= prog_target;
        r_cfg_pol[prog_id]    <= prog_polarity;
        r_cfg_mode[prog_id]   <= prog_mode;
      end

      if (w_emit_good && (r_pend_good[w_tgt] != c_MAX))
        r_pend_good[w_tgt] <= r_pend_good[w_tgt] + NEW_TOKEN_BITS'(1);
      if (w_emit_bad && (r_pend_bad[w_tgt] != c_MAX))
        r_pend_bad[w_tgt] <= r_pend_bad[w_tgt] + NEW_TOKEN_BITS'(1);

      if (hold) begin
        new_good_tokens <= '0;
        new_bad_tokens  <= '0;
        out_valid       <= 1'b0;
      end else begin
        new_good_tokens <= r_pend_good[processor_id];
        new_bad_tokens  <= r_pend_bad[processor_id];
        out_valid       <= 1'b1;
        out_id          <= processor_id;
        // Clear overrides the increment above; a same-cycle self-loop token survives as 1.
        r_pend_good[processor_id] <= NEW_TOKEN_BITS'(w_emit_good && w_self);
        r_pend_bad[processor_id]  <= NEW_TOKEN_BITS'(w_emit_bad && w_self);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_jleugeri_ttt_token_router.sv
`default_nettype none
// ==========================================================================
// tb_tt_um_jleugeri_ttt_token_router
// Randomized and directed stimulus scored against a token-count model.
// Revision: 1.0
// ==========================================================================
module tb_tt_um_jleugeri_ttt_token_router;

  localparam int NTB = 8;
  localparam int NP  = 10;
  localparam int W   = 4;
  localparam int SAT = 255;

  typedef struct {
    logic           valid;
    logic [W-1:0]   id;
    logic [NTB-1:0] good;
    logic [NTB-1:0] bad;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset, hold, prog_en, prog_polarity;
  logic [W-1:0]   processor_id, prog_id, prog_target;
  logic [1:0]     token_startstop, prog_mode;
  logic [NTB-1:0] new_good_tokens, new_bad_tokens;
  logic           out_valid;
  logic [W-1:0]   out_id;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: unbounded token counts, clipped to the counter range on delivery.
  int m_tgt [16];
  int m_pol [16];
  int m_mode[16];
  int m_pg  [16];
  int m_pb  [16];
  int last_id;

  tt_um_jleugeri_ttt_token_router #(.NEW_TOKEN_BITS(NTB), .NUM_PROCESSORS(NP)) dut (
    .clock_fast      (clk),
    .reset           (reset),
    .hold            (hold),
    .processor_id    (processor_id),
    .token_startstop (token_startstop),
    .prog_en         (prog_en),
    .prog_id         (prog_id),
    .prog_target     (prog_target),
    .prog_polarity   (prog_polarity),
    .prog_mode       (prog_mode),
    .new_good_tokens (new_good_tokens),
    .new_bad_tokens  (new_bad_tokens),
    .out_valid       (out_valid),
    .out_id          (out_id)
  );

  always #5 clk = ~clk;

  function automatic int clip(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic drive(input bit rst, input bit h, input int pid, input int tss,
                       input bit pen, input int pi, input int pt, input int pp, input int pm);
    exp_t e;
    bit   tok;
    @(negedge clk);
    reset = rst; hold = h; processor_id = W'(pid); token_startstop = 2'(tss);
    prog_en = pen; prog_id = W'(pi); prog_target = W'(pt);
    prog_polarity = pp[0]; prog_mode = 2'(pm);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        m_tgt[i] = 0; m_pol[i] = 0; m_mode[i] = 0; m_pg[i] = 0; m_pb[i] = 0;
      end
      last_id = 0;
      e = '{1'b0, '0, '0, '0};
    end else begin
      tok = 1'b0;
      if (pid < NP)
        tok = (tss == 1 && (m_mode[pid] == 1 || m_mode[pid] == 3)) ||
              (tss == 2 && (m_mode[pid] == 2 || m_mode[pid] == 3));
      if (!h) begin
        e = '{1'b1, W'(pid), NTB'(clip(m_pg[pid])), NTB'(clip(m_pb[pid]))};
        m_pg[pid] = 0; m_pb[pid] = 0;
        last_id = pid;
      end else begin
        e = '{1'b0, W'(last_id), '0, '0};
      end
      if (tok) begin
        if (m_pol[pid] != 0) m_pb[m_tgt[pid]]++;
        else                 m_pg[m_tgt[pid]]++;
      end
      if (pen && pi < NP && pt < NP) begin
        m_tgt[pi] = pt; m_pol[pi] = pp; m_mode[pi] = pm;
      end
    end
    q.push_back(e);
  endtask

  task automatic ev(input int pid, input int tss);
    drive(1'b0, 1'b0, pid, tss, 1'b0, 0, 0, 0, 0);
  endtask

  task automatic prog(input int s, input int t, input int p, input int m);
    drive(1'b0, 1'b0, 9, 0, 1'b1, s, t, p, m);
  endtask

  // Monitor: one registered response per clock, compared after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if (out_valid !== e.valid || out_id !== e.id ||
            new_good_tokens !== e.good || new_bad_tokens !== e.bad) begin
          n_fail++;
          $display("FAIL delivery @%0t: got valid=%b id=%0d good=%0d bad=%0d, expected valid=%b id=%0d good=%0d bad=%0d",
                   $time, out_valid, out_id, new_good_tokens, new_bad_tokens,
                   e.valid, e.id, e.good, e.bad);
        end
      end
    end
  end

  initial begin
    drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0);

    // Basic route 2 -> 5, good, on start
    prog(2, 5, 0, 1);
    ev(2, 1); ev(5, 0); ev(5, 0);

    // Bad polarity, emit on stop only
    prog(3, 4, 1, 2);
    ev(3, 1); ev(4, 0); ev(3, 2); ev(4, 0);

    // Saturation of target 1
    prog(2, 1, 0, 1);
    repeat (300) ev(2, 1);
    ev(1, 0);

    // Self-loop on 6 with three tokens already pending
    prog(6, 6, 0, 3);
    prog(0, 6, 0, 1);
    repeat (3) ev(0, 1);
    ev(6, 1); ev(6, 0);

    // Hold keeps pending counts and still accumulates
    prog(0, 7, 0, 1);
    ev(0, 1); ev(0, 1);
    drive(1'b0, 1'b1, 7, 1, 1'b0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 0, 1, 1'b0, 0, 0, 0, 0);
    ev(7, 0);

    // Mid-operation reset wipes config and counters, ignoring that cycle's inputs
    ev(0, 1); ev(0, 1);
    drive(1'b1, 1'b1, 0, 1, 1'b1, 0, 7, 0, 3);
    for (int s = 0; s < NP; s++) begin ev(s, 1); ev(s, 2); end
    for (int s = 0; s < NP; s++) ev(s, 0);

    // Same-cycle program and event from one source uses the old config
    drive(1'b0, 1'b0, 5, 1, 1'b1, 5, 8, 0, 1);
    ev(5, 1); ev(8, 0);

    // Randomized traffic, including out-of-range IDs
    for (int n = 0; n < 3000; n++) begin
      int pid;
      pid = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, NP - 1);
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0), pid,
            $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
            $urandom_range(0, 11), $urandom_range(0, 11),
            $urandom_range(0, 1), $urandom_range(0, 3));
    end

    @(negedge clk);
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d responses left unchecked, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
